// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned STARVE_LIMIT_DEF = 4;

    // Width of a counter that must hold the values 0..limit inclusive
    function automatic int unsigned starve_cnt_w(input int unsigned limit);
        return 32'($clog2(limit + 1));
    endfunction

    localparam int unsigned STARVE_CNT_W = starve_cnt_w(STARVE_LIMIT_DEF);

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_RESP = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_D    = 2'd2
    } gnt_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and data requesters.
// ARB_ROUND_ROBIN_EN selects round-robin instead of fixed data priority
// with a fetch starvation counter.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned CNT_W        = STARVE_CNT_W,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic             if_valid,
    input  logic             d_valid,
    input  logic [CNT_W-1:0] starve_cnt,
    input  gnt_t             last_gnt,
    output gnt_t             gnt_c
);

`ifdef ARB_ROUND_ROBIN_EN
    localparam int unsigned UNUSED_LIMIT = STARVE_LIMIT;
    logic unused_starve;
    assign unused_starve = ^starve_cnt;

    // Contested: whoever was granted last loses; reset state favours data
    always_comb begin
        gnt_c = GNT_NONE;
        if (if_valid && d_valid) begin
            gnt_c = (last_gnt == GNT_D) ? GNT_IF : GNT_D;
        end else if (if_valid) begin
            gnt_c = GNT_IF;
        end else if (d_valid) begin
            gnt_c = GNT_D;
        end
    end
`else
    logic unused_last;
    assign unused_last = ^2'(last_gnt);

    // Contested: data wins unless fetch has lost STARVE_LIMIT times in a row
    always_comb begin
        gnt_c = GNT_NONE;
        if (if_valid && d_valid) begin
            gnt_c = (starve_cnt == CNT_W'(STARVE_LIMIT)) ? GNT_IF : GNT_D;
        end else if (if_valid) begin
            gnt_c = GNT_IF;
        end else if (d_valid) begin
            gnt_c = GNT_D;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and
// load/store, one access in flight (IDLE accept, RESP return).
// Optional macro ARB_ROUND_ROBIN_EN switches arbitration to round-robin.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned DEPTH_WORDS  = 8192,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              d_valid,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = starve_cnt_w(STARVE_LIMIT);

    arb_state_t       state_q, state_d;
    gnt_t             gnt_q, gnt_d;
    gnt_t             last_gnt_q, last_gnt_d;
    logic             err_q, err_d;
    logic             we_q, we_d;
    logic [CNT_W-1:0] starve_q, starve_d;

    logic              if_req_c;
    logic              d_req_c;
    gnt_t              pick_c;
    logic [ADDR_W-1:0] req_addr_c;
    logic              in_range_c;
    logic              resp_c;

    // Requests are masked while reset is asserted so every output stays low
    assign if_req_c = if_valid & rst_n;
    assign d_req_c  = d_valid & rst_n;

    mem_arb_pick #(
        .CNT_W        (CNT_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .if_valid   (if_req_c),
        .d_valid    (d_req_c),
        .starve_cnt (starve_q),
        .last_gnt   (last_gnt_q),
        .gnt_c      (pick_c)
    );

    // Winner address and unsigned full-width range check
    assign req_addr_c = (pick_c == GNT_IF) ? if_addr : d_addr;
    assign in_range_c = (req_addr_c < ADDR_W'(DEPTH_WORDS));

    // Next-state, grant handshakes and memory strobes
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        err_d      = err_q;
        we_d       = we_q;
        starve_d   = starve_q;
        if_ready   = 1'b0;
        d_ready    = 1'b0;
        mem_addr   = '0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = '0;

        case (state_q)
            ARB_IDLE: begin
                if (pick_c != GNT_NONE) begin
                    if_ready   = (pick_c == GNT_IF);
                    d_ready    = (pick_c == GNT_D);
                    gnt_d      = pick_c;
                    last_gnt_d = pick_c;
                    err_d      = ~in_range_c;
                    we_d       = (pick_c == GNT_D) && d_we;
                    state_d    = ARB_RESP;
                    if (in_range_c) begin
                        mem_addr = req_addr_c;
                        if ((pick_c == GNT_D) && d_we) begin
                            mem_we    = 1'b1;
                            mem_wdata = d_wdata;
                        end else begin
                            mem_re = 1'b1;
                        end
                    end
                end
                // Fetch starvation tracking: clear on fetch grant, count losses
                if (pick_c == GNT_IF) begin
                    starve_d = '0;
                end else if (if_req_c && (starve_q != CNT_W'(STARVE_LIMIT))) begin
                    starve_d = starve_q + CNT_W'(1);
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
                gnt_d   = GNT_NONE;
                err_d   = 1'b0;
                we_d    = 1'b0;
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = GNT_NONE;
            end
        endcase
    end

    // Response return for the latched winner; data masked on store or error
    always_comb begin
        resp_c    = (state_q == ARB_RESP);
        if_rvalid = resp_c && (gnt_q == GNT_IF);
        d_rvalid  = resp_c && (gnt_q == GNT_D);
        if_err    = if_rvalid && err_q;
        d_err     = d_rvalid && err_q;
        if_rdata  = (if_rvalid && !err_q) ? mem_rdata : '0;
        d_rdata   = (d_rvalid && !err_q && !we_q) ? mem_rdata : '0;
    end

    // State and arbitration history registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            gnt_q      <= GNT_NONE;
            last_gnt_q <= GNT_NONE;
            err_q      <= 1'b0;
            we_q       <= 1'b0;
            starve_q   <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            err_q      <= err_d;
            we_q       <= we_d;
            starve_q   <= starve_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous memory.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_addr;
    logic        if_ready;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_valid;
    logic [31:0] d_addr;
    logic        d_we;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:8191];
    logic        any_out;

    mem_port_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_valid  (if_valid),
        .if_addr   (if_addr),
        .if_ready  (if_ready),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .d_valid   (d_valid),
        .d_addr    (d_addr),
        .d_we      (d_we),
        .d_wdata   (d_wdata),
        .d_ready   (d_ready),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    assign any_out = |{if_ready, if_rvalid, if_rdata, if_err, d_ready, d_rvalid, d_rdata,
                       d_err, mem_addr, mem_re, mem_we, mem_wdata};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: pattern-initialised, read data one cycle after mem_re
    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 32'hA500_0000 | 32'(i);
        mem_rdata = 32'h0;
    end
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[12:0]] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr[12:0]];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One data access starting just after a rising edge; ends just after T+2 edge
    task automatic d_access(input string tag, input logic [31:0] addr, input logic we,
                            input logic [31:0] wdata, input logic [31:0] exp_rdata,
                            input logic exp_err);
        d_valid = 1'b1; d_addr = addr; d_we = we; d_wdata = wdata;
        @(negedge clk);
        chk({tag, "_d_ready"}, 64'(d_ready), 64'd1);
        chk({tag, "_if_ready"}, 64'(if_ready), 64'd0);
        chk({tag, "_mem_re"}, 64'(mem_re), 64'(!we && !exp_err));
        chk({tag, "_mem_we"}, 64'(mem_we), 64'(we && !exp_err));
        chk({tag, "_mem_addr"}, 64'(mem_addr), exp_err ? 64'd0 : 64'(addr));
        if (we && !exp_err) chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(wdata));
        @(posedge clk); #1;
        d_valid = 1'b0; d_we = 1'b0;
        @(negedge clk);
        chk({tag, "_d_rvalid"}, 64'(d_rvalid), 64'd1);
        chk({tag, "_d_rdata"}, 64'(d_rdata), 64'(exp_rdata));
        chk({tag, "_d_err"}, 64'(d_err), 64'(exp_err));
        chk({tag, "_resp_quiet"}, 64'({d_ready, if_ready, mem_re, mem_we}), 64'd0);
        @(posedge clk); #1;
    endtask

    // One fetch access, data side must stay silent throughout
    task automatic f_access(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp_rdata, input logic exp_err);
        if_valid = 1'b1; if_addr = addr;
        @(negedge clk);
        chk({tag, "_if_ready"}, 64'(if_ready), 64'd1);
        chk({tag, "_mem_re"}, 64'(mem_re), 64'(!exp_err));
        chk({tag, "_d_side"}, 64'({d_ready, d_rvalid, d_err, d_rdata}), 64'd0);
        @(posedge clk); #1;
        if_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_if_rvalid"}, 64'(if_rvalid), 64'd1);
        chk({tag, "_if_rdata"}, 64'(if_rdata), 64'(exp_rdata));
        chk({tag, "_if_err"}, 64'(if_err), 64'(exp_err));
        chk({tag, "_d_side_resp"}, 64'({d_ready, d_rvalid, d_err, d_rdata}), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic exp_if;
        rst_n = 1'b0; if_valid = 1'b0; if_addr = '0;
        d_valid = 1'b1; d_addr = 32'd5; d_we = 1'b0; d_wdata = '0;

        // Reset holds every output low even with a pending request
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", 64'(any_out), 64'd0);

        // Load accepted, then reset lands in the RESP cycle
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_d_ready", 64'(d_ready), 64'd1);
        chk("rstmid_mem_re", 64'(mem_re), 64'd1);
        chk("rstmid_mem_addr", 64'(mem_addr), 64'd5);
        @(posedge clk); #1;
        d_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstmid_no_rvalid", 64'(d_rvalid), 64'd0);
        chk("rstmid_outputs", 64'(any_out), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 64'(any_out), 64'd0);
        @(posedge clk); #1;
        d_access("reload5", 32'd5, 1'b0, 32'h0, 32'hA500_0005, 1'b0);

        // Store then back-to-back load of the same word
        d_access("store10", 32'h10, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0);
        d_access("load10", 32'h10, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Fetch alone
        f_access("fetch20", 32'h20, 32'hA500_0020, 1'b0);

        // Out-of-range on both ports, including the first illegal word
        d_access("d_oor", 32'd8192, 1'b0, 32'h0, 32'h0, 1'b1);
        d_access("d_last", 32'd8191, 1'b0, 32'h0, 32'hA500_1FFF, 1'b0);
        f_access("if_oor", 32'hFFFF_FFFF, 32'h0, 1'b1);

        // Continuous contention
        if_valid = 1'b1; if_addr = 32'h20;
        d_valid = 1'b1; d_addr = 32'h30; d_we = 1'b0;
        for (int i = 0; i < 10; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_if = (i % 2) == 1;
`else
            exp_if = (i % 5) == 4;
`endif
            @(negedge clk);
            chk($sformatf("cont%0d_if_ready", i), 64'(if_ready), 64'(exp_if));
            chk($sformatf("cont%0d_d_ready", i), 64'(d_ready), 64'(!exp_if));
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("cont%0d_if_rvalid", i), 64'(if_rvalid), 64'(exp_if));
            chk($sformatf("cont%0d_d_rvalid", i), 64'(d_rvalid), 64'(!exp_if));
            chk($sformatf("cont%0d_rdata", i), 64'(exp_if ? if_rdata : d_rdata),
                exp_if ? 64'h0000_0000_A500_0020 : 64'h0000_0000_A500_0030);
            @(posedge clk); #1;
        end
        if_valid = 1'b0; d_valid = 1'b0;

        // Nothing requested: idle with all strobes low
        @(negedge clk);
        chk("idle_quiet", 64'(any_out), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
